regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised multi-read-port integer register file with an integrated busy-bit scoreboard and write-to-read bypass.
- Sits between decode/issue and writeback in the NPC core.
- Issue allocates a destination register, which marks it busy. Writeback writes the value and clears busy.
- Readers get data plus a per-port ready flag for hazard detection.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, ≥2.
- AW, $clog2(NREGS), register address width (derived; not overridden).
- NREAD, 2, number of combinational read ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low.
- wen  in  1  writeback write enable.
- rd_addr  in  AW  writeback destination index.
- rd_data  in  WIDTH  writeback data.
- rs_addr  in  NREAD*AW  packed read addresses; port i at [i*AW +: AW].
- rs_data  out  NREAD*WIDTH  packed read data; port i at [i*WIDTH +: WIDTH].
- rs_ready  out  NREAD  port i operand valid (not pending).
- alloc_valid  in  1  issue requests to mark alloc_addr busy.
- alloc_addr  in  AW  register being allocated.
- alloc_ready  out  1  allocation accepted this cycle (combinational).
- flush  in  1  pipeline flush; clears all busy bits.
- busy_count  out  $clog2(NREGS+1)  registered count of busy registers.

Behaviour:
- Reset (rst low, async):
  - all registers cleared to 0.
  - all busy bits cleared.
  - busy_count = 0.
  - Combinational outputs follow: rs_data = 0, rs_ready = all 1s.
- Register 0 is hardwired:
  - reads 0, never busy.
  - writes and allocs to it are ignored; alloc_ready = 1 for it.
- Write: on posedge with wen and rd_addr≠0:
  - regs[rd_addr] ← rd_data.
  - busy[rd_addr] cleared, unless an accepted alloc to the same address occurs that cycle.
  - Writing a non-busy register is legal.
- Read port i, combinational:
  - addr 0 → data 0, ready 1.
  - else if BYPASS and wen and rd_addr==addr → data rd_data, ready 1.
  - else data regs[addr], ready = !busy[addr].
  - With BYPASS=0, a same-cycle write is not visible: old data, ready = !busy.
- Allocation:
  - alloc_ready = (alloc_addr==0) | !busy[alloc_addr] | (wen & rd_addr==alloc_addr).
  - A WAW to a still-pending register stalls until its writeback.
  - Accepted (alloc_valid & alloc_ready & alloc_addr≠0 & !flush) → busy[alloc_addr] set next cycle.
- Same-cycle write and alloc to the same address: busy ends at 1 (new producer wins); data is still written.
- flush:
  - next cycle, all busy bits are 0.
  - an alloc in the same cycle is discarded.
  - a write in the same cycle still commits data.
  - alloc_ready is not gated by flush.
- busy_count:
  - Registered popcount of next-state busy vector; updates the same edge as busy.
  - Range 0..NREGS-1.
  - No wrap possible, since register 0 is never busy.
- Latency: write/alloc/flush take effect at the next posedge; reads are 0-cycle.
- Reset asserted mid-operation: all state cleared immediately; pending allocs are lost.

Decomposition:
- Package regfile_pkg holds:
  - default WIDTH/NREGS constants.
  - reg_idx_t typedef (logic [AW-1:0]).
  - ZERO_REG localparam.
- One natural sub-module, regfile_scoreboard. It holds:
  - busy vector.
  - alloc_ready logic.
  - flush handling.
  - busy_count popcount.
- regfile_sb owns the storage array, read muxes, and bypass.

Test Plan:
- Reset then read: release rst, rs_addr={5,0} → rs_data={0,0}, rs_ready=2'b11, busy_count=0.
- Alloc then writeback:
  - alloc x5 → next cycle rs_ready[0]=0 for x5, busy_count=1.
  - wen x5=32'hDEADBEEF → same cycle rs_data=DEADBEEF, rs_ready=1 (BYPASS=1); next cycle busy_count=0.
- WAW stall: x7 busy, alloc x7 with no write → alloc_ready=0. Same cycle wen x7=1 → alloc_ready=1; next cycle x7 still busy, regs[7]=1.
- x0 handling: wen x0=32'hFFFF_FFFF and alloc x0 → rs x0 reads 0, ready=1, busy_count unchanged.
- Flush: alloc x1,x2,x3 over three cycles (busy_count=3). Then flush with alloc x4 and wen x9=42 → next cycle busy_count=0, x4 not busy, regs[9]=42.
- Async reset mid-run: regs[3]=7 and x3 busy. Drop rst between edges → immediately rs_data(x3)=0, rs_ready=1, busy_count=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded integer register file.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0] reg_idx_t;

    localparam int       ZERO_REG     = 0;
    localparam reg_idx_t ZERO_REG_IDX = reg_idx_t'(ZERO_REG);

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer, gates
// WAW allocation and keeps a registered popcount of pending registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [AW-1:0]    rd_addr,
    input  logic             alloc_valid,
    input  logic [AW-1:0]    alloc_addr,
    input  logic             flush,
    output logic             alloc_ready,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_count
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic             alloc_accept;

    // A writeback landing this cycle frees the slot for a new producer.
    always_comb begin
        alloc_ready = (alloc_addr == AW'(ZERO_REG))
                    | !busy_q[alloc_addr]
                    | (wen && (rd_addr == alloc_addr));
    end

    assign alloc_accept = alloc_valid && alloc_ready
                       && (alloc_addr != AW'(ZERO_REG)) && !flush;

    // Clear on writeback first, then set on allocation so the new producer wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (wen && (rd_addr == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (alloc_accept && (alloc_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy       = busy_q;
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with busy scoreboard and optional
// write-to-read bypass; register 0 is hardwired to zero and never busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREGS  = DEF_NREGS,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic [AW-1:0]          rd_addr,
    input  logic [WIDTH-1:0]       rd_data,
    input  logic [NREAD*AW-1:0]    rs_addr,
    output logic [NREAD*WIDTH-1:0] rs_data,
    output logic [NREAD-1:0]       rs_ready,
    input  logic                   alloc_valid,
    input  logic [AW-1:0]          alloc_addr,
    output logic                   alloc_ready,
    input  logic                   flush,
    output logic [CW-1:0]          busy_count
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_en;

    assign wr_en = wen && (rd_addr != AW'(ZERO_REG));

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .rd_addr     (rd_addr),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .alloc_ready (alloc_ready),
        .busy        (busy),
        .busy_count  (busy_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_addr] <= rd_data;
        end
    end

    // Address 0 takes priority over bypass so a write to x0 is never visible.
    always_comb begin
        rs_data  = '0;
        rs_ready = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (rs_addr[p*AW +: AW] == AW'(ZERO_REG)) begin
                rs_data[p*WIDTH +: WIDTH] = '0;
                rs_ready[p]               = 1'b1;
            end else if ((BYPASS != 0) && wen && (rd_addr == rs_addr[p*AW +: AW])) begin
                rs_data[p*WIDTH +: WIDTH] = rd_data;
                rs_ready[p]               = 1'b1;
            end else begin
                rs_data[p*WIDTH +: WIDTH] = regs_q[rs_addr[p*AW +: AW]];
                rs_ready[p]               = !busy[rs_addr[p*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters (32x32, 2 read ports, bypass on).
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_ready;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        alloc_ready;
    logic        flush;
    logic [5:0]  busy_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_ready    (rs_ready),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .flush       (flush),
        .busy_count  (busy_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen         = 1'b0;
        rd_addr     = '0;
        rd_data     = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        rs_addr = {5'd0, 5'd5};
        #12;
        tests_run++;
        if (rs_data !== 64'h0) begin
            tests_failed++; $display("FAIL reset_rs_data: got %h expected %h", rs_data, 64'h0);
        end
        tests_run++;
        if (rs_ready !== 2'b11) begin
            tests_failed++; $display("FAIL reset_rs_ready: got %b expected %b", rs_ready, 2'b11);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (busy_count !== 6'd0) begin
            tests_failed++; $display("FAIL reset_busy_count: got %0d expected 0", busy_count);
        end
        tests_run++;
        if (rs_data !== 64'h0 || rs_ready !== 2'b11) begin
            tests_failed++; $display("FAIL post_reset_read: got %h/%b expected 0/11", rs_data, rs_ready);
        end
    endtask

    task automatic test_alloc_writeback();
        rs_addr     = {5'd0, 5'd5};
        alloc_valid = 1'b1;
        alloc_addr  = 5'd5;
        #1;
        tests_run++;
        if (alloc_ready !== 1'b1) begin
            tests_failed++; $display("FAIL alloc5_ready: got %b expected 1", alloc_ready);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (rs_ready !== 2'b10 || busy_count !== 6'd1) begin
            tests_failed++; $display("FAIL alloc5_busy: ready %b count %0d expected 10 / 1", rs_ready, busy_count);
        end
        wen     = 1'b1;
        rd_addr = 5'd5;
        rd_data = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (rs_data[31:0] !== 32'hDEADBEEF || rs_ready[0] !== 1'b1) begin
            tests_failed++; $display("FAIL bypass_x5: got %h/%b expected deadbeef/1", rs_data[31:0], rs_ready[0]);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (busy_count !== 6'd0 || rs_data[31:0] !== 32'hDEADBEEF || rs_ready !== 2'b11) begin
            tests_failed++;
            $display("FAIL wb_x5_commit: count %0d data %h ready %b expected 0 deadbeef 11", busy_count, rs_data[31:0], rs_ready);
        end
    endtask

    task automatic test_waw_stall();
        rs_addr     = {5'd5, 5'd7};
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        tick();
        #1;
        tests_run++;
        if (alloc_ready !== 1'b0) begin
            tests_failed++; $display("FAIL waw_stall: alloc_ready %b expected 0", alloc_ready);
        end
        wen     = 1'b1;
        rd_addr = 5'd7;
        rd_data = 32'h1;
        #1;
        tests_run++;
        if (alloc_ready !== 1'b1) begin
            tests_failed++; $display("FAIL waw_release: alloc_ready %b expected 1", alloc_ready);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (rs_ready !== 2'b10 || rs_data !== {32'hDEADBEEF, 32'h1} || busy_count !== 6'd1) begin
            tests_failed++;
            $display("FAIL waw_new_producer: ready %b data %h count %0d expected 10 deadbeef00000001 1", rs_ready, rs_data, busy_count);
        end
        wen     = 1'b1;
        rd_addr = 5'd7;
        rd_data = 32'h77;
        tick();
        idle();
        #1;
        tests_run++;
        if (busy_count !== 6'd0 || rs_data[31:0] !== 32'h77 || rs_ready !== 2'b11) begin
            tests_failed++; $display("FAIL waw_final_wb: count %0d data %h ready %b expected 0 77 11", busy_count, rs_data[31:0], rs_ready);
        end
    endtask

    task automatic test_x0();
        rs_addr     = {5'd0, 5'd0};
        wen         = 1'b1;
        rd_addr     = 5'd0;
        rd_data     = 32'hFFFF_FFFF;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd0;
        #1;
        tests_run++;
        if (alloc_ready !== 1'b1 || rs_data !== 64'h0 || rs_ready !== 2'b11) begin
            tests_failed++; $display("FAIL x0_same_cycle: ar %b data %h ready %b expected 1 0 11", alloc_ready, rs_data, rs_ready);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (rs_data !== 64'h0 || rs_ready !== 2'b11 || busy_count !== 6'd0) begin
            tests_failed++; $display("FAIL x0_after: data %h ready %b count %0d expected 0 11 0", rs_data, rs_ready, busy_count);
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            alloc_valid = 1'b1;
            alloc_addr  = 5'(r);
            tick();
        end
        idle();
        #1;
        tests_run++;
        if (busy_count !== 6'd3) begin
            tests_failed++; $display("FAIL flush_pre_count: got %0d expected 3", busy_count);
        end
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd4;
        wen         = 1'b1;
        rd_addr     = 5'd9;
        rd_data     = 32'd42;
        tick();
        idle();
        rs_addr = {5'd9, 5'd4};
        #1;
        tests_run++;
        if (busy_count !== 6'd0 || rs_ready !== 2'b11 || rs_data[63:32] !== 32'd42) begin
            tests_failed++;
            $display("FAIL flush_result: count %0d ready %b x9 %0d expected 0 11 42", busy_count, rs_ready, rs_data[63:32]);
        end
        rs_addr = {5'd2, 5'd1};
        #1;
        tests_run++;
        if (rs_ready !== 2'b11) begin
            tests_failed++; $display("FAIL flush_x1x2_ready: got %b expected 11", rs_ready);
        end
    endtask

    task automatic test_async_reset();
        rs_addr = {5'd5, 5'd3};
        wen     = 1'b1;
        rd_addr = 5'd3;
        rd_data = 32'd7;
        tick();
        idle();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd3;
        tick();
        idle();
        #1;
        tests_run++;
        if (rs_data[31:0] !== 32'd7 || rs_ready !== 2'b10 || busy_count !== 6'd1) begin
            tests_failed++;
            $display("FAIL areset_pre: x3 %0d ready %b count %0d expected 7 10 1", rs_data[31:0], rs_ready, busy_count);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (rs_data !== 64'h0 || rs_ready !== 2'b11 || busy_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL areset_clear: data %h ready %b count %0d expected 0 11 0", rs_data, rs_ready, busy_count);
        end
        tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if (rs_data !== 64'h0 || busy_count !== 6'd0) begin
            tests_failed++; $display("FAIL areset_release: data %h count %0d expected 0 0", rs_data, busy_count);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_writeback();
        test_waw_stall();
        test_x0();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
